// File: rtl/uart_tx.sv
// uart_tx: byte-serial UART transmitter, 8N1, LSB first, valid/ready core side.
// A one-entry holding buffer allows back-to-back frames with no idle gap.
// Optional build macro UART_TX_PARITY_EN adds an even-parity bit (8E1).
module uart_tx #(
    parameter int unsigned CLK_PER_BIT = 868
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       txd,
    output logic       busy
);

    localparam int unsigned TW = (CLK_PER_BIT > 1) ? $clog2(CLK_PER_BIT) : 1;
    localparam logic [TW-1:0] TimerMax = TW'(CLK_PER_BIT - 1);

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;
`else
    typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;
`endif

    state_e          state_q, state_d;
    logic [TW-1:0]   timer_q, timer_d;
    logic [2:0]      idx_q, idx_d;
    logic [7:0]      shift_q, shift_d;
    logic [7:0]      buf_q, buf_d;
    logic            buf_full_q, buf_full_d;
    logic            txd_q, txd_d;
`ifdef UART_TX_PARITY_EN
    logic            parity_q, parity_d;
`endif

    logic accept;
    logic timer_end;
    logic take_direct;

    assign tx_ready    = ~buf_full_q;
    assign busy        = (state_q != StIdle) | buf_full_q;
    assign txd         = txd_q;
    assign accept      = tx_valid & tx_ready;
    assign timer_end   = (timer_q == TimerMax);
    // Byte bypasses the buffer when the shifter is free on this edge.
    assign take_direct = (state_q == StIdle) | ((state_q == StStop) & timer_end);

    // Next-state logic for the frame FSM, bit timer, shifter and holding buffer.
    always_comb begin
        state_d    = state_q;
        timer_d    = timer_q;
        idx_d      = idx_q;
        shift_d    = shift_q;
        buf_d      = buf_q;
        buf_full_d = buf_full_q;
`ifdef UART_TX_PARITY_EN
        parity_d   = parity_q;
`endif

        if (state_q != StIdle) begin
            timer_d = timer_end ? '0 : timer_q + 1'b1;
        end

        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    shift_d = tx_data;
`ifdef UART_TX_PARITY_EN
                    parity_d = ^tx_data;
`endif
                    timer_d = '0;
                    state_d = StStart;
                end
            end
            StStart: begin
                if (timer_end) begin
                    idx_d   = 3'd0;
                    state_d = StData;
                end
            end
            StData: begin
                if (timer_end) begin
                    shift_d = {1'b0, shift_q[7:1]};
                    if (idx_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        state_d = StParity;
`else
                        state_d = StStop;
`endif
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            StParity: begin
                if (timer_end) state_d = StStop;
            end
`endif
            StStop: begin
                if (timer_end) begin
                    if (buf_full_q) begin
                        shift_d    = buf_q;
`ifdef UART_TX_PARITY_EN
                        parity_d   = ^buf_q;
`endif
                        buf_full_d = 1'b0;
                        state_d    = StStart;
                    end else if (accept) begin
                        shift_d = tx_data;
`ifdef UART_TX_PARITY_EN
                        parity_d = ^tx_data;
`endif
                        state_d = StStart;
                    end else begin
                        state_d = StIdle;
                    end
                end
            end
            default: state_d = StIdle;
        endcase

        // Buffer and drain never coincide: tx_ready is low while full.
        if (accept && !take_direct) begin
            buf_d      = tx_data;
            buf_full_d = 1'b1;
        end
    end

    // Serial line value for the coming cycle, so txd comes straight off a flop.
    always_comb begin
        txd_d = 1'b1;
        unique case (state_d)
            StStart:  txd_d = 1'b0;
            StData:   txd_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
            StParity: txd_d = parity_d;
`endif
            default:  txd_d = 1'b1;
        endcase
    end

    // State registers; reset abandons any frame and drives the line high at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StIdle;
            timer_q    <= '0;
            idx_q      <= 3'd0;
            shift_q    <= 8'h00;
            buf_q      <= 8'h00;
            buf_full_q <= 1'b0;
            txd_q      <= 1'b1;
`ifdef UART_TX_PARITY_EN
            parity_q   <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            timer_q    <= timer_d;
            idx_q      <= idx_d;
            shift_q    <= shift_d;
            buf_q      <= buf_d;
            buf_full_q <= buf_full_d;
            txd_q      <= txd_d;
`ifdef UART_TX_PARITY_EN
            parity_q   <= parity_d;
`endif
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: directed bench for uart_tx with CLK_PER_BIT=4.
// Honors UART_TX_PARITY_EN to expect 8E1 frames.
module tb_uart_tx;

    localparam int unsigned CPB = 4;
`ifdef UART_TX_PARITY_EN
    localparam int unsigned NBITS = 11;
`else
    localparam int unsigned NBITS = 10;
`endif
    localparam int FLEN = NBITS * CPB;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       txd;
    logic       busy;

    int total = 0;
    int bad   = 0;

    uart_tx #(.CLK_PER_BIT(CPB)) dut (
        .clk      (clk),
        .rst      (rst),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .txd      (txd),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Move to 1ns after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expected line level k cycles into a frame that starts with its start bit.
    function automatic logic frame_bit(input logic [7:0] b, input int k);
        int n;
        n = k / CPB;
        if (n == 0) return 1'b0;
        if (n <= 8) return b[n-1];
`ifdef UART_TX_PARITY_EN
        if (n == 9) return ^b;
`endif
        return 1'b1;
    endfunction

    // Hand over one byte from idle and check the whole frame plus the return to idle.
    task automatic send_frame(input logic [7:0] b);
        tx_data  = b;
        tx_valid = 1'b1;
        check("ready_before_accept", tx_ready, 1);
        tick();
        tx_valid = 1'b0;
        for (int c = 0; c < FLEN; c++) begin
            check("frame_txd", txd, frame_bit(b, c));
            check("frame_busy", busy, 1);
            tick();
        end
        check("end_busy", busy, 0);
        check("end_ready", tx_ready, 1);
        check("end_txd", txd, 1);
    endtask

    logic [7:0] seq [3];

    initial begin
        rst      = 1'b1;
        tx_valid = 1'b0;
        tx_data  = 8'h00;
        #2;
        check("rst_txd", txd, 1);
        check("rst_busy", busy, 0);
        check("rst_ready", tx_ready, 1);
        tick();
        tick();
        rst = 1'b0;
        for (int c = 0; c < 20; c++) begin
            check("idle_txd", txd, 1);
            check("idle_ready", tx_ready, 1);
            check("idle_busy", busy, 0);
            tick();
        end

        // Single byte.
        send_frame(8'h55);

        // Back-to-back: A3, then 0F into the buffer, then 3C offered while full.
        seq[0] = 8'hA3;
        seq[1] = 8'h0F;
        seq[2] = 8'h3C;
        tx_data  = 8'hA3;
        tx_valid = 1'b1;
        tick();
        for (int c = 0; c < 3 * FLEN; c++) begin
            check("b2b_txd", txd, frame_bit(seq[c / FLEN], c % FLEN));
            check("b2b_busy", busy, 1);
            if (c == 0) begin
                check("b2b_ready_empty", tx_ready, 1);
                tx_data = 8'h0F;
            end else if (c == 1) begin
                check("b2b_ready_full", tx_ready, 0);
                tx_data = 8'h3C;
            end else if (c < FLEN) begin
                check("b2b_ready_held", tx_ready, 0);
            end else if (c == FLEN) begin
                check("b2b_ready_drained", tx_ready, 1);
            end else if (c == FLEN + 1) begin
                check("b2b_ready_third", tx_ready, 0);
                tx_valid = 1'b0;
            end
            tick();
        end
        check("b2b_end_busy", busy, 0);
        check("b2b_end_txd", txd, 1);
        check("b2b_end_ready", tx_ready, 1);

        // Reset mid-DATA of FF with 12 buffered.
        tx_data  = 8'hFF;
        tx_valid = 1'b1;
        tick();
        tx_data = 8'h12;
        tick();
        tx_valid = 1'b0;
        for (int c = 1; c < 3 * CPB; c++) tick();
        check("mid_data_busy", busy, 1);
        check("mid_data_ready", tx_ready, 0);
        rst = 1'b1;
        #2;
        check("async_rst_txd", txd, 1);
        check("async_rst_busy", busy, 0);
        check("async_rst_ready", tx_ready, 1);
        tick();
        tick();
        rst = 1'b0;
        for (int c = 0; c < 2 * FLEN; c++) begin
            check("post_rst_txd", txd, 1);
            check("post_rst_busy", busy, 0);
            check("post_rst_ready", tx_ready, 1);
            tick();
        end

        // Reset during a start bit: line must go high before the next edge.
        tx_data  = 8'h00;
        tx_valid = 1'b1;
        tick();
        tx_valid = 1'b0;
        tick();
        check("start_txd_low", txd, 0);
        rst = 1'b1;
        #2;
        check("start_rst_txd", txd, 1);
        check("start_rst_busy", busy, 0);
        tick();
        rst = 1'b0;
        tick();

        // Recovery after reset.
        send_frame(8'h81);

`ifdef UART_TX_PARITY_EN
        // Parity bit for 07 is 1, for 03 is 0; frames are 44 cycles.
        send_frame(8'h07);
        send_frame(8'h03);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/uart_tx.md
Name: uart_tx

Overview:
- Byte-serial UART transmitter: 8N1 frames on the serial output line, LSB first.
- The core's output path (out instruction / MMIO store) feeds it; it pairs with the board-side receiver the host drives.
- Core side is a valid/ready handshake.
- A one-entry holding buffer lets the core hand over the next byte while the current frame shifts out, so frames go back-to-back with no idle gap.

Parameters:
- CLK_PER_BIT, 868, clock cycles per serial bit (100 MHz / 115200 baud); legal range >= 2.

Ports:
- clk  input  1  system clock; all state on rising edge
- rst  input  1  asynchronous, active-high reset
- tx_data  input  8  byte to send; sampled on an accept edge
- tx_valid  input  1  core offers tx_data
- tx_ready  output  1  transmitter can accept a byte this cycle
- txd  output  1  serial line; idle high
- busy  output  1  a frame is in progress or a byte is buffered

Behaviour:
- Interface (already decided): one clock, clk; rst is asynchronous and active-high.
- Reset (asserted at any time, including mid-frame):
  - txd=1, busy=0, tx_ready=1.
  - FSM=IDLE, bit counter=0, buffer empty.
  - Any partial frame is abandoned; the line returns high immediately.
- Accept: a byte is taken on a rising edge where tx_valid & tx_ready.
- tx_ready = ~buf_full. It is combinational from registered state only, with no path from tx_valid.
- FSM states: IDLE, START, DATA, STOP (plus PARITY with the optional feature).
- Bit timer: counts 0..CLK_PER_BIT-1, width $clog2(CLK_PER_BIT). Each state holds txd for exactly CLK_PER_BIT cycles; the timer wraps to 0 on every state or bit change.
- IDLE:
  - txd=1.
  - Accept with buffer empty: byte loads straight into the shift register, FSM->START, txd<=0 on the same edge.
  - txd is therefore low in the first cycle after the handshake (latency 1).
- START:
  - txd=0.
  - At timer end: FSM->DATA, bit index=0.
- DATA:
  - txd=shift[0].
  - At timer end: shift right, index+1. After index 7 completes: FSM->STOP.
- STOP:
  - txd=1.
  - At timer end:
    - If buffer full: buffer moves to the shift register, buffer empties, FSM->START (no idle cycle).
    - Else if an accept happens on this same edge: the new byte goes directly to the shift register, FSM->START.
    - Else: FSM->IDLE.
- Accept while FSM != IDLE: byte goes into the buffer, buf_full=1, so tx_ready drops the next cycle.
- A simultaneous accept and buffer drain on the same edge cannot occur, because tx_ready=0 while the buffer is full.
- tx_valid while tx_ready=0: ignored; tx_data is not sampled.
- Frame length: exactly 10*CLK_PER_BIT cycles (11*CLK_PER_BIT with parity).
- busy = (FSM != IDLE) | buf_full.
  - Registered-state derived; 1 from the cycle after the accept edge until the last STOP cycle of the final frame.
  - 0 in the cycle FSM re-enters IDLE.
- txd is driven from a flop (glitch-free).

Optional Feature:
- Macro: UART_TX_PARITY_EN.
- Defined:
  - Adds a PARITY state between DATA and STOP.
  - txd = even parity (XOR of the 8 data bits, computed at load) for CLK_PER_BIT cycles.
  - Frame = 11 bits (8E1).
- Undefined: no PARITY state, no parity logic; DATA goes directly to STOP (8N1).

Test Plan (CLK_PER_BIT=4 unless stated):
- Reset, then idle for 20 cycles -> txd=1, tx_ready=1, busy=0 throughout.
- Single byte 0x55 accepted at edge T:
  - txd=0 for cycles T+1..T+4.
  - Then the data bits LSB first, 4 cycles each: 1,0,1,0,1,0,1,0.
  - Then stop=1 for 4 cycles.
  - busy falls at T+41; total frame 40 cycles.
- Back-to-back: 0xA3 accepted at T, 0x0F held valid:
  - 0x0F accepted at T+1; tx_ready=0 from T+2.
  - Second start bit begins at T+41 with no idle cycle.
  - tx_ready returns to 1 at T+41.
- Third byte offered while the buffer is full -> not accepted (tx_ready=0); sent after 0x0F once ready rises; serial output is exactly three frames in order.
- rst asserted mid-DATA of byte 0xFF with a buffered 0x12:
  - txd=1 asynchronously, before the next clock edge.
  - After release: idle, tx_ready=1, busy=0; 0x12 is never transmitted.
- With UART_TX_PARITY_EN, byte 0x07 -> parity bit=1 after the data bits; 44-cycle frame.
- With UART_TX_PARITY_EN, byte 0x03 -> parity bit=0.
